// File: rtl/bitserial_logic_ctrl.sv
// bitserial_logic_ctrl
// Time-shares one external 1-bit gate unit across a WIDTH-bit word.
// Bits are processed LSB first, one per cycle, and the result word is assembled in place.
//
// Ports:
//   clk, rst          - system clock; synchronous active-high reset
//   start, op, a, b   - request pulse, operation (0 AND,1 OR,2 XOR,3 NOT,4 NAND,5 NOR), operands
//   gate_op/a/b       - drive to the shared gate unit (all zero outside RUN)
//   gate_c            - combinational gate unit output
//   busy, done, err   - status; done is a one-cycle pulse, err flags an illegal op
//   result            - assembled word, held until the next accepted start
module bitserial_logic_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       gate_op,
    output logic             gate_a,
    output logic             gate_b,
    input  logic             gate_c,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic             accept_c;
    logic             illegal_c;
    logic             gate_a_n;
    logic             gate_b_n;
    logic [2:0]       gate_op_n;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, plus the gate drive for the coming cycle so the gate outputs can be registered
    always_comb begin
        state_n   = state;
        accept_c  = 1'b0;
        illegal_c = (op > OP_MAX);
        idx_nx    = idx + IDX_W'(1);
        gate_a_n  = 1'b0;
        gate_b_n  = 1'b0;
        gate_op_n = 3'd0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept_c = 1'b1;
                    if (illegal_c) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n   = ST_RUN;
                        gate_a_n  = a[0];
                        gate_b_n  = (op == OP_NOT) ? 1'b0 : b[0];
                        gate_op_n = op;
                    end
                end
            end
            ST_RUN: begin
                if (idx == LAST_IDX) begin
                    state_n = ST_DONE;
                end else begin
                    gate_a_n  = a_reg[idx_nx];
                    gate_b_n  = (op_reg == OP_NOT) ? 1'b0 : b_reg[idx_nx];
                    gate_op_n = op_reg;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand capture, bit index, result assembly and registered status/gate outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= 3'd0;
            idx     <= '0;
            result  <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            gate_op <= 3'd0;
        end else begin
            busy    <= (state_n != ST_IDLE);
            done    <= (state_n == ST_DONE);
            gate_a  <= gate_a_n;
            gate_b  <= gate_b_n;
            gate_op <= gate_op_n;
            if (accept_c) begin
                result <= '0;
                err    <= illegal_c;
                idx    <= '0;
                if (!illegal_c) begin
                    a_reg  <= a;
                    b_reg  <= b;
                    op_reg <= op;
                end
            end else if (state == ST_RUN) begin
                result[idx] <= gate_c;
                // idx parks at the last bit; it is cleared on the next accepted start
                if (idx != LAST_IDX) begin
                    idx <= idx_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitserial_logic_ctrl.sv
// Testbench for bitserial_logic_ctrl (WIDTH=8) with a behavioural gate unit.
// Stimulus pushes expected transactions into a scoreboard queue; a negedge monitor
// checks gate drive, busy and done every cycle and compares result/err on done.
module tb_bitserial_logic_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       gate_op;
    logic             gate_a;
    logic             gate_b;
    logic             gate_c;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             err;
        logic             legal;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        int               t0;
    } exp_t;

    exp_t sb_q[$];

    bitserial_logic_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .gate_op(gate_op), .gate_a(gate_a), .gate_b(gate_b), .gate_c(gate_c),
        .busy(busy), .done(done), .err(err), .result(result)
    );

    // Shared gate unit
    always_comb begin
        case (gate_op)
            3'd0:    gate_c = gate_a & gate_b;
            3'd1:    gate_c = gate_a | gate_b;
            3'd2:    gate_c = gate_a ^ gate_b;
            3'd3:    gate_c = ~gate_a;
            3'd4:    gate_c = ~(gate_a & gate_b);
            3'd5:    gate_c = ~(gate_a | gate_b);
            default: gate_c = 1'b0;
        endcase
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        bit         has;
        exp_t       e;
        int         d;
        int         lat;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ga;
        logic       exp_gb;
        logic [2:0] exp_gop;
        if (!rst) begin
            has      = (sb_q.size() > 0);
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_ga   = 1'b0;
            exp_gb   = 1'b0;
            exp_gop  = 3'd0;
            if (has) begin
                e   = sb_q[0];
                d   = cyc - e.t0;
                lat = e.legal ? WIDTH : 0;
                exp_busy = (d >= 0) && (d <= lat);
                exp_done = (d == lat);
                if (e.legal && d >= 0 && d < WIDTH) begin
                    exp_ga  = e.a[d];
                    exp_gb  = (e.op == 3'd3) ? 1'b0 : e.b[d];
                    exp_gop = e.op;
                end
            end
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("gate_drive", {27'd0, gate_op, gate_a, gate_b}, {27'd0, exp_gop, exp_ga, exp_gb});
            if (has && exp_done) begin
                chk("result", 32'(result), 32'(e.res));
                chk("err", 32'(err), 32'(e.err));
                void'(sb_q.pop_front());
            end
        end
    end

    // Drive start for one cycle and record the expected transaction when it will be accepted
    task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] res, input logic e_err);
        exp_t e;
        start = 1'b1; op = o; a = va; b = vb;
        e.res = res; e.err = e_err; e.legal = ~e_err; e.a = va; e.b = vb; e.op = o; e.t0 = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_result", 32'(result), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk); #1;

        // AND
        issue(3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        wait_done("and");
        chk("and_result_hold", 32'(result), 32'h30);

        // NOR
        issue(3'd5, 8'hAA, 8'h0F, 8'h50, 1'b0);
        wait_done("nor");

        // NOT, b must not reach the gate unit
        issue(3'd3, 8'h5A, 8'hFF, 8'hA5, 1'b0);
        wait_done("not");

        // Illegal op: one-cycle latency, err held afterwards
        issue(3'd6, 8'hFF, 8'hFF, 8'h00, 1'b1);
        wait_done("illegal");
        chk("err_hold", 32'(err), 32'h1);
        chk("illegal_result", 32'(result), 32'h0);

        // XOR with a start pulse mid-run that must be ignored
        issue(3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        repeat (2) @(posedge clk); #1;
        start = 1'b1; op = 3'd2; a = 8'h00; b = 8'h0F;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("xor_ignore");
        chk("err_cleared", 32'(err), 32'h0);

        // XOR aborted by reset in cycle T0+4
        issue(3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sb_q.delete();
        rst = 1'b0;
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        repeat (12) @(posedge clk); #1;
        issue(3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0);
        wait_done("xor_after_reset");

        // start held high: an operation completes every WIDTH+2 cycles
        start = 1'b1; op = 3'd4; a = 8'hF0; b = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.res = 8'hCF; e.err = 1'b0; e.legal = 1'b1; e.a = 8'hF0; e.b = 8'h3C; e.op = 3'd4;
            e.t0 = cyc + 1;
            sb_q.push_back(e);
            repeat (WIDTH + 2) @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done("back_to_back");
        repeat (3) @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bitserial_logic_ctrl.md
# bitserial_logic_ctrl

Sequencer that time-shares one 1-bit logic gate unit (AND/OR/XOR/NOT/NAND/NOR, selected by a 3-bit op) across a WIDTH-bit word. It processes one bit per cycle, LSB first, and assembles the result word. It sits between the MPU instruction stage and the shared gate unit. The instruction stage issues a start pulse with operands and waits for done.

## Interface

Parameters:
- WIDTH, 8: operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only when busy=0.
- op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NOT (of a), 4 NAND, 5 NOR; 6–7 illegal.
- a  input  WIDTH  operand A, sampled on accepted start.
- b  input  WIDTH  operand B, sampled on accepted start; ignored for NOT.
- gate_op  output  3  op select to the shared gate unit.
- gate_a  output  1  current bit of A to the gate unit.
- gate_b  output  1  current bit of B to the gate unit.
- gate_c  input  1  gate unit output, combinational from gate_a/gate_b/gate_op.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- err  output  1  high with done when op was illegal; held until next accepted start.
- result  output  WIDTH  assembled result; holds until next accepted start.

## Operation

- States: IDLE, RUN, DONE. Reset value is IDLE.
- IDLE with start=1 and op<=5:
  - capture a, b, op into a_reg, b_reg, op_reg;
  - clear result and err;
  - set idx=0;
  - next state RUN.
- IDLE with start=1 and op>=6:
  - result=0, err=1;
  - next state DONE; the gate unit is never driven.
- RUN, each cycle:
  - gate_a=a_reg[idx], gate_b=(op_reg==3 ? 0 : b_reg[idx]), gate_op=op_reg;
  - at the clock edge, result[idx] <= gate_c;
  - if idx==WIDTH-1, next state DONE; otherwise idx <= idx+1.
- DONE: done=1 for exactly this cycle, then IDLE unconditionally.
- start is ignored whenever busy=1. This includes the DONE cycle; there is no back-to-back acceptance.
- Outside RUN: gate_a=0, gate_b=0, gate_op=0.
- idx width is clog2(WIDTH). It never wraps past WIDTH-1.
- Reset in any state:
  - next cycle is IDLE;
  - result=0, err=0, done=0, busy=0, idx=0;
  - an in-flight operation is discarded with no done pulse.
- rst has priority over start in the same cycle.

## Timing

- Reset values: busy=0, done=0, err=0, result=0, gate_a=0, gate_b=0, gate_op=0.
- Start accepted at edge T0. RUN occupies cycles T0+1 .. T0+WIDTH, with bit k driven in cycle T0+1+k.
- done is high in cycle T0+WIDTH+1. result is fully valid in that same cycle. Total latency is WIDTH+1 cycles.
- Illegal op: done and err are high in cycle T0+1, so latency is 1 cycle.
- Earliest next accepted start is at the edge ending the done cycle +1, i.e. the first cycle in IDLE.
- Partial result bits update during RUN. Consumers read result only on done.

## Test plan

Bench instantiates the controller with WIDTH=8 and a gate unit model built from the team's gate modules, muxed by gate_op.

- AND, a=0xF0, b=0x3C, start at T0 -> result=0x30, done high in T0+9 only, err=0, busy high in T0+1..T0+9.
- NOR, a=0xAA, b=0x0F -> result=0x50. Check gate_a/gate_b per RUN cycle equal bits 0..7 of a/b.
- NOT, a=0x5A, b=0xFF -> result=0xA5, and gate_b=0 in every RUN cycle.
- op=6, start -> done=1 and err=1 in T0+1, result=0x00, gate_a/gate_b/gate_op stay 0.
- XOR, a=0xFF, b=0x0F:
  - pulse start again at T0+3 with a=0x00 -> ignored, result=0xF0 at T0+9;
  - assert rst at T0+4 on a repeated run -> IDLE, result=0, no done pulse, next start works normally.
- Back-to-back: start held high continuously -> operations complete every 10 cycles; each done pulse is exactly 1 cycle.
